// File: rtl/decode_stage_p.sv
// ID stage: register file, instruction decode, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage_p #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] pc4D,
    input  logic            regwriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    input  logic            stallD,
    input  logic            flushE,
    output logic            ldhazD,
    output logic            regwriteE,
    output logic            memrwE,
    output logic            memrdE,
    output logic            aselE,
    output logic            bselE,
    output logic [1:0]      wbselE,
    output logic [3:0]      ALUselE,
    output logic [2:0]      brtypeE,
    output logic            jalrE,
    output logic            illegalE,
    output logic [4:0]      rdE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [XLEN-1:0] rd1E,
    output logic [XLEN-1:0] rd2E,
    output logic [XLEN-1:0] imm_exE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] pc4E
);
    localparam int         IDXW   = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic            regwrite;
        logic            memrw;
        logic            memrd;
        logic            asel;
        logic            bsel;
        logic [1:0]      wbsel;
        logic [3:0]      alusel;
        logic [2:0]      brtype;
        logic            jalr;
        logic            illegal;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } idex_t;

    // ALU op shared by OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] rf_q [NREG];
    idex_t           idex_q, idex_d, dec;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic        rs1_ok, rs2_ok, rd_ok, shamt_ok;
    logic        use_rs1, use_rs2, use_rd, legal;
    logic [31:0] imm32;
    logic [XLEN-1:0] rd1, rd2;

    assign opcode   = instrD[6:0];
    assign funct3   = instrD[14:12];
    assign funct7   = instrD[31:25];
    assign rd_idx   = instrD[11:7];
    assign rs1_idx  = instrD[19:15];
    assign rs2_idx  = instrD[24:20];
    assign rs1_ok   = {1'b0, rs1_idx} < NREG_L;
    assign rs2_ok   = {1'b0, rs2_idx} < NREG_L;
    assign rd_ok    = {1'b0, rd_idx} < NREG_L;
    assign shamt_ok = (XLEN == 64) || !instrD[25];

    // Register file write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (regwriteW && (rdW != 5'd0) && ({1'b0, rdW} < NREG_L))
            rf_q[rdW[IDXW-1:0]] <= resultW;
    end

    // Combinational reads with x0 hardwired and optional WB bypass
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1_idx != 5'd0 && rs1_ok)
            rd1 = (WB_BYPASS != 0 && regwriteW && rdW == rs1_idx) ? resultW
                                                                 : rf_q[rs1_idx[IDXW-1:0]];
        if (rs2_idx != 5'd0 && rs2_ok)
            rd2 = (WB_BYPASS != 0 && regwriteW && rdW == rs2_idx) ? resultW
                                                                 : rf_q[rs2_idx[IDXW-1:0]];
    end

    // Main decode: control bits, immediate, register-use flags, legality
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        legal   = 1'b1;
        imm32   = '0;
        dec.rd  = rd_idx;
        dec.rs1 = rs1_idx;
        dec.rs2 = rs2_idx;
        dec.rd1 = rd1;
        dec.rd2 = rd2;
        dec.pc  = pcD;
        dec.pc4 = pc4D;
        case (opcode)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                dec.regwrite = 1'b1;
                dec.alusel   = alu_op(funct3, funct7[5]);
                legal = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OPIMM: begin
                {use_rs1, use_rd} = 2'b11;
                dec.regwrite = 1'b1;
                dec.bsel     = 1'b1;
                dec.alusel   = alu_op(funct3, (funct3 == 3'b101) && instrD[30]);
                imm32        = {{20{instrD[31]}}, instrD[31:20]};
                if (funct3 == 3'b001)
                    legal = (instrD[31:26] == 6'd0) && shamt_ok;
                else if (funct3 == 3'b101)
                    legal = !instrD[31] && (instrD[29:26] == 4'd0) && shamt_ok;
            end
            OPC_LOAD: begin
                {use_rs1, use_rd} = 2'b11;
                dec.regwrite = 1'b1;
                dec.memrd    = 1'b1;
                dec.bsel     = 1'b1;
                dec.wbsel    = 2'd1;
                imm32        = {{20{instrD[31]}}, instrD[31:20]};
                legal        = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                dec.memrw = 1'b1;
                dec.bsel  = 1'b1;
                imm32     = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
                legal     = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                dec.asel = 1'b1;
                dec.bsel = 1'b1;
                imm32    = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                            instrD[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec.brtype = 3'd1;
                    3'b001:  dec.brtype = 3'd2;
                    3'b100:  dec.brtype = 3'd3;
                    3'b101:  dec.brtype = 3'd4;
                    3'b110:  dec.brtype = 3'd5;
                    3'b111:  dec.brtype = 3'd6;
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                use_rd       = 1'b1;
                dec.regwrite = 1'b1;
                dec.asel     = 1'b1;
                dec.bsel     = 1'b1;
                dec.wbsel    = 2'd2;
                dec.brtype   = 3'd7;
                imm32        = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                                instrD[30:21], 1'b0};
            end
            OPC_JALR: begin
                {use_rs1, use_rd} = 2'b11;
                dec.regwrite = 1'b1;
                dec.bsel     = 1'b1;
                dec.wbsel    = 2'd2;
                dec.brtype   = 3'd7;
                dec.jalr     = 1'b1;
                imm32        = {{20{instrD[31]}}, instrD[31:20]};
                legal        = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                use_rd       = 1'b1;
                dec.regwrite = 1'b1;
                dec.bsel     = 1'b1;
                dec.alusel   = ALU_PASSB;
                imm32        = {instrD[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                use_rd       = 1'b1;
                dec.regwrite = 1'b1;
                dec.asel     = 1'b1;
                dec.bsel     = 1'b1;
                imm32        = {instrD[31:12], 12'd0};
            end
            default: legal = 1'b0;
        endcase
        dec.imm = XLEN'($signed(imm32));
        legal = legal && (!use_rs1 || rs1_ok) && (!use_rs2 || rs2_ok) && (!use_rd || rd_ok);
        if (!legal) begin
            dec.regwrite = 1'b0;
            dec.memrw    = 1'b0;
            dec.memrd    = 1'b0;
            dec.asel     = 1'b0;
            dec.bsel     = 1'b0;
            dec.wbsel    = 2'd0;
            dec.alusel   = ALU_ADD;
            dec.brtype   = 3'd0;
            dec.jalr     = 1'b0;
            dec.illegal  = 1'b1;
        end
    end

    assign ldhazD = idex_q.memrd && (idex_q.rd != 5'd0) &&
                    ((use_rs1 && idex_q.rd == rs1_idx) || (use_rs2 && idex_q.rd == rs2_idx));

    // ID/EX next value: flush or unstalled load-use bubble, else hold on stall, else load
    always_comb begin
        idex_d = idex_q;
        if (flushE || (ldhazD && !stallD))
            idex_d = '0;
        else if (!stallD)
            idex_d = dec;
    end

    // ID/EX pipeline register; all-zero is the bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign regwriteE = idex_q.regwrite;
    assign memrwE    = idex_q.memrw;
    assign memrdE    = idex_q.memrd;
    assign aselE     = idex_q.asel;
    assign bselE     = idex_q.bsel;
    assign wbselE    = idex_q.wbsel;
    assign ALUselE   = idex_q.alusel;
    assign brtypeE   = idex_q.brtype;
    assign jalrE     = idex_q.jalr;
    assign illegalE  = idex_q.illegal;
    assign rdE       = idex_q.rd;
    assign rs1E      = idex_q.rs1;
    assign rs2E      = idex_q.rs2;
    assign rd1E      = idex_q.rd1;
    assign rd2E      = idex_q.rd2;
    assign imm_exE   = idex_q.imm;
    assign pcE       = idex_q.pc;
    assign pc4E      = idex_q.pc4;

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instrD = '0, pcD = '0, pc4D = '0, resultW = '0;
    logic        regwriteW = 1'b0, stallD = 1'b0, flushE = 1'b0;
    logic [4:0]  rdW = '0;

    logic        ldhazD, regwriteE, memrwE, memrdE, aselE, bselE, jalrE, illegalE;
    logic [1:0]  wbselE;
    logic [3:0]  ALUselE;
    logic [2:0]  brtypeE;
    logic [4:0]  rdE, rs1E, rs2E;
    logic [31:0] rd1E, rd2E, imm_exE, pcE, pc4E;

    logic        b_ldhazD, b_regwriteE, b_memrwE, b_memrdE, b_aselE, b_bselE, b_jalrE, b_illegalE;
    logic [1:0]  b_wbselE;
    logic [3:0]  b_ALUselE;
    logic [2:0]  b_brtypeE;
    logic [4:0]  b_rdE, b_rs1E, b_rs2E;
    logic [31:0] b_rd1E, b_rd2E, b_imm_exE, b_pcE, b_pc4E;

    decode_stage_p #(.XLEN(32), .NREG(32), .WB_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .pc4D(pc4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .stallD(stallD), .flushE(flushE),
        .ldhazD(ldhazD), .regwriteE(regwriteE), .memrwE(memrwE), .memrdE(memrdE),
        .aselE(aselE), .bselE(bselE), .wbselE(wbselE), .ALUselE(ALUselE), .brtypeE(brtypeE),
        .jalrE(jalrE), .illegalE(illegalE), .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E),
        .rd1E(rd1E), .rd2E(rd2E), .imm_exE(imm_exE), .pcE(pcE), .pc4E(pc4E));

    decode_stage_p #(.XLEN(32), .NREG(16), .WB_BYPASS(0)) dut_e (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .pc4D(pc4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .stallD(stallD), .flushE(flushE),
        .ldhazD(b_ldhazD), .regwriteE(b_regwriteE), .memrwE(b_memrwE), .memrdE(b_memrdE),
        .aselE(b_aselE), .bselE(b_bselE), .wbselE(b_wbselE), .ALUselE(b_ALUselE),
        .brtypeE(b_brtypeE), .jalrE(b_jalrE), .illegalE(b_illegalE), .rdE(b_rdE),
        .rs1E(b_rs1E), .rs2E(b_rs2E), .rd1E(b_rd1E), .rd2E(b_rd2E), .imm_exE(b_imm_exE),
        .pcE(b_pcE), .pc4E(b_pc4E));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input bit rw, input bit mw, input bit mr, input bit as,
                                       input bit bs, input bit [1:0] wb, input bit [3:0] alu,
                                       input bit [2:0] br, input bit j, input bit il);
        return {rw, mw, mr, as, bs, wb, alu, br, j, il};
    endfunction

    function automatic logic [15:0] actl();
        return {regwriteE, memrwE, memrdE, aselE, bselE, wbselE, ALUselE, brtypeE, jalrE, illegalE};
    endfunction

    function automatic logic [15:0] bctl();
        return {b_regwriteE, b_memrwE, b_memrdE, b_aselE, b_bselE, b_wbselE, b_ALUselE,
                b_brtypeE, b_jalrE, b_illegalE};
    endfunction

    initial begin
        tbl[0]  = '{32'h00A00093, mk(1,0,0,0,1,0,0,0,0,0),  32'd10,       5'd1};  // ADDI x1,x0,10
        tbl[1]  = '{32'h00528333, mk(1,0,0,0,0,0,0,0,0,0),  32'd0,        5'd6};  // ADD x6,x5,x5
        tbl[2]  = '{32'h403100B3, mk(1,0,0,0,0,0,1,0,0,0),  32'd0,        5'd1};  // SUB
        tbl[3]  = '{32'h40315093, mk(1,0,0,0,1,0,7,0,0,0),  32'h403,      5'd1};  // SRAI
        tbl[4]  = '{32'hFFF13093, mk(1,0,0,0,1,0,4,0,0,0),  32'hFFFFFFFF, 5'd1};  // SLTIU -1
        tbl[5]  = '{32'h0000A183, mk(1,0,1,0,1,1,0,0,0,0),  32'd0,        5'd3};  // LW x3,0(x1)
        tbl[6]  = '{32'h0020A423, mk(0,1,0,0,1,0,0,0,0,0),  32'd8,        5'd8};  // SW x2,8(x1)
        tbl[7]  = '{32'hFE20CCE3, mk(0,0,0,1,1,0,0,3,0,0),  32'hFFFFFFF8, 5'd25}; // BLT -8
        tbl[8]  = '{32'h004100E7, mk(1,0,0,0,1,2,0,7,1,0),  32'd4,        5'd1};  // JALR x1,4(x2)
        tbl[9]  = '{32'h001000EF, mk(1,0,0,1,1,2,0,7,0,0),  32'h800,      5'd1};  // JAL x1,2048
        tbl[10] = '{32'h00001237, mk(1,0,0,0,1,0,10,0,0,0), 32'h1000,     5'd4};  // LUI x4,1
        tbl[11] = '{32'hFFFFF297, mk(1,0,0,1,1,0,0,0,0,0),  32'hFFFFF000, 5'd5};  // AUIPC
        tbl[12] = '{32'h0000007F, mk(0,0,0,0,0,0,0,0,0,1),  32'd0,        5'd0};  // opcode 7F
        tbl[13] = '{32'h00002063, mk(0,0,0,0,0,0,0,0,0,1),  32'd0,        5'd0};  // branch f3=010
        tbl[14] = '{32'h00000003, mk(0,0,0,0,0,0,0,0,0,1),  32'd0,        5'd0};  // LB
        tbl[15] = '{32'h003140B3, mk(1,0,0,0,0,0,5,0,0,0),  32'd0,        5'd1};  // XOR
        tbl[16] = '{32'h403110B3, mk(0,0,0,0,0,0,0,0,0,1),  32'd0,        5'd1};  // SLL with f7=20
        tbl[17] = '{32'h0020F863, mk(0,0,0,1,1,0,0,6,0,0),  32'd16,       5'd16}; // BGEU +16

        // reset state
        #12;
        chk("reset_ctrl", 64'(actl()), 64'd0);
        chk("reset_regs", {27'd0, rdE, imm_exE}, 64'd0);
        chk("reset_pc", {pcE, pc4E}, 64'd0);
        rst_n = 1'b1;

        // table-driven decode
        for (int i = 0; i < 18; i++) begin
            instrD = tbl[i].instr;
            pcD    = 32'h100 + 32'(4 * i);
            pc4D   = 32'h104 + 32'(4 * i);
            step();
            chk($sformatf("ctrl[%0d]", i), 64'(actl()), 64'(tbl[i].ctrl));
            chk($sformatf("rd[%0d]", i), 64'(rdE), 64'(tbl[i].rd));
            chk($sformatf("pc[%0d]", i), {pcE, pc4E}, {32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i)});
            if (!tbl[i].ctrl[0])
                chk($sformatf("imm[%0d]", i), 64'(imm_exE), 64'(tbl[i].imm));
        end

        // WB bypass vs no bypass
        instrD = 32'h00000013; regwriteW = 1'b1; rdW = 5'd5; resultW = 32'h55;
        step();
        instrD = 32'h00528333; resultW = 32'h1234;
        step();
        regwriteW = 1'b0;
        chk("bypass_rd1", 64'(rd1E), 64'h1234);
        chk("bypass_rd2", 64'(rd2E), 64'h1234);
        chk("nobypass_rd1", 64'(b_rd1E), 64'h55);
        step();
        chk("x5_written", 64'(b_rd1E), 64'h1234);

        // load-use hazard
        instrD = 32'h0000A183; step();
        chk("lw_in_ex", 64'(memrdE), 64'd1);
        instrD = 32'h00018233; #1; chk("haz_add_rs1", 64'(ldhazD), 64'd1);
        instrD = 32'h0030A023; #1; chk("haz_sw_rs2", 64'(ldhazD), 64'd1);
        instrD = 32'h00308213; #1; chk("nohaz_addi", 64'(ldhazD), 64'd0);
        instrD = 32'h00018237; #1; chk("nohaz_lui", 64'(ldhazD), 64'd0);
        instrD = 32'h00018233; step();
        chk("haz_bubble", 64'(actl()), 64'd0);
        chk("haz_cleared", 64'(ldhazD), 64'd0);
        step();
        chk("after_bubble", {48'd0, actl()}, 64'(mk(1,0,0,0,0,0,0,0,0,0)));
        chk("after_bubble_rd", 64'(rdE), 64'd4);
        instrD = 32'h0000A003; step();
        instrD = 32'h00000233; #1;
        chk("nohaz_x0", 64'(ldhazD), 64'd0);

        // stall holds, flush beats stall
        instrD = 32'h00A00093; step();
        stallD = 1'b1; instrD = 32'h003140B3;
        step(); step();
        chk("stall_ctrl", 64'(actl()), 64'(mk(1,0,0,0,1,0,0,0,0,0)));
        chk("stall_imm", 64'(imm_exE), 64'd10);
        chk("stall_rd", 64'(rdE), 64'd1);
        flushE = 1'b1; step();
        chk("flush_stall_ctrl", 64'(actl()), 64'd0);
        chk("flush_stall_rd", 64'(rdE), 64'd0);
        flushE = 1'b0; stallD = 1'b0;

        // x0 is never written or bypassed
        instrD = 32'h00000333; regwriteW = 1'b1; rdW = 5'd0; resultW = 32'hFF;
        step();
        chk("x0_bypass", 64'(rd1E), 64'd0);
        regwriteW = 1'b0;
        step();
        chk("x0_read", {rd1E, rd2E}, 64'd0);

        // index beyond NREG on the RV32E instance
        instrD = 32'h00100893; step();
        chk("rv32e_illegal", 64'(bctl()), 64'h1);
        chk("rv32e_rd", 64'(b_rdE), 64'd17);
        chk("rv32i_x17", 64'(actl()), 64'(mk(1,0,0,0,1,0,0,0,0,0)));

        // asynchronous reset mid-stream
        instrD = 32'h00A00093; step();
        chk("pre_reset", 64'(regwriteE), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'(actl()), 64'd0);
        chk("async_rst_data", {27'd0, rdE, imm_exE}, 64'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised ID stage of the 5-stage RISC-V pipeline. Successor to the fixed 32-bit decode block.
- Contains the register file, main/ALU control decode and immediate generation, plus the ID/EX pipeline register.
- Adds over the previous generation:
  - XLEN/NREG generalisation
  - full RV32I base decode (branches, JALR, LUI, AUIPC)
  - stall/flush control
  - load-use hazard detection
  - WB-to-ID bypass
  - illegal-instruction flag

Parameters:
- XLEN, 32, datapath width; 32 or 64; immediates and pc sign/zero-extended to XLEN.
- NREG, 32, architectural registers; 32 (RV32I) or 16 (RV32E); index field = $clog2(NREG) bits.
- WB_BYPASS, 1, 1 = a read of the register being written by WB the same cycle returns resultW.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instrD  in  32  instruction in ID
- pcD  in  XLEN  pc of instrD
- pc4D  in  XLEN  pc+4 of instrD
- regwriteW  in  1  WB write enable
- rdW  in  5  WB destination
- resultW  in  XLEN  WB data
- stallD  in  1  hold ID/EX register
- flushE  in  1  load bubble into ID/EX
- ldhazD  out  1  load-use hazard detected (combinational)
- regwriteE  out  1  write enable to EX
- memrwE  out  1  1 = store
- memrdE  out  1  1 = load
- aselE  out  1  0 = rs1, 1 = pc
- bselE  out  1  0 = rs2, 1 = imm
- wbselE  out  2  0 = ALU, 1 = mem, 2 = pc+4
- ALUselE  out  4  ALU op
- brtypeE  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL/JALR
- jalrE  out  1  target = rs1+imm
- illegalE  out  1  illegal instruction in EX
- rdE / rs1E / rs2E  out  5 each  register indices
- rd1E / rd2E  out  XLEN each  register operands
- imm_exE  out  XLEN  sign-extended immediate
- pcE / pc4E  out  XLEN each  pc values

Behaviour:
- Reset (async, rst_n=0):
  - All ID/EX outputs go to 0, which is a bubble: no write, no store, no load, brtype 0, illegal 0.
  - Register file contents are not reset; x0 always reads 0.
- Register file:
  - Written on posedge when regwriteW=1 and rdW!=0.
  - Reads are combinational.
  - WB_BYPASS=1: if regwriteW and rdW==rsX and rdW!=0, the read returns resultW.
  - WB_BYPASS=0: the read returns the old value.
- ALUsel encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - R-type and I-ALU ops decode from funct3/funct7[5].
  - SUB exists only for R-type.
  - SRAI uses funct7[5].
- Immediates:
  - I, S, B (bit0=0), U (low 12 = 0) and J (bit0=0) formats, sign-extended to XLEN.
  - R-type immediate = 0.
- Control by opcode:
  - OP: regwrite, bsel 0, wbsel 0.
  - OP-IMM: regwrite, bsel 1, wbsel 0.
  - LOAD (funct3 010 only): regwrite, memrd, bsel 1, wbsel 1, ALU ADD.
  - STORE (funct3 010 only): memrw, bsel 1, ALU ADD.
  - BRANCH: asel 1, bsel 1, ALU ADD, brtype from funct3; funct3 010/011 are illegal.
  - JAL: regwrite, asel 1, bsel 1, wbsel 2, brtype 7.
  - JALR (funct3 000): as JAL plus jalr=1 and asel 0.
  - LUI: regwrite, bsel 1, ALU PASSB.
  - AUIPC: regwrite, asel 1, bsel 1, ALU ADD.
- Illegal instruction:
  - Any other opcode/funct combination, or an rs1/rs2/rd index ≥ NREG, sets illegalE=1.
  - All other control bits are forced to 0, so the instruction is a bubble.
  - Index/pc fields still pass through.
- ID/EX register update priority on posedge:
  1. flushE=1 or ldhazD=1 (with stallD=0): load the bubble.
  2. stallD=1: hold all outputs.
  3. Otherwise: load the decoded values.
  - Flush beats stall.
- ldhazD = memrdE & (rdE!=0) & ((rdE==rs1 used by instrD) | (rdE==rs2 used by instrD)).
  - "Used" excludes rs2 for I/U/J formats and rs1 for U/J formats.
  - The pipeline controller combines ldhazD into stallF/stallD.
- Width: pcE/pc4E copy pcD/pc4D unchanged.

Test Plan:
1. ADDI x1,x0,10, then posedge -> regwriteE=1, bselE=1, ALUselE=0, imm_exE=10, rdE=1, wbselE=0.
2. regwriteW=1, rdW=5, resultW=0x1234 while instrD=ADD x6,x5,x5 -> rd1E=rd2E=0x1234 next edge (WB_BYPASS=1); with WB_BYPASS=0 -> the old x5 value.
3. LW x3,0(x1) latched in EX, then instrD=ADD x4,x3,x0 -> ldhazD=1; next edge bubble (regwriteE=0, memrdE=0). With instrD=LUI x4,1 instead -> ldhazD=0.
4. BLT x1,x2,-8 -> brtypeE=3, imm_exE=0xFFFFFFF8. JALR x1,4(x2) -> jalrE=1, brtypeE=7, wbselE=2, aselE=0.
5. stallD=1 for 2 cycles -> outputs unchanged. stallD=1 and flushE=1 together -> bubble. Write rdW=0 with resultW=0xFF -> a later read of x0 returns 0.
6. Opcode 0x7F, or NREG=16 with rd=17 -> illegalE=1 and all control bits 0. Asserting rst_n=0 mid-stream -> outputs clear immediately without waiting for a clock edge.
